// File: rtl/doc_safety_heartbeat_sched.sv
// Heartbeat scheduler: pulses generate_bit once per window in which every task checked in,
// counts consecutive failed windows and latches a sticky fault after MAX_MISSES of them.
module doc_safety_heartbeat_sched #(
  parameter int unsigned NUM_TASKS     = 4,
  parameter int unsigned PERIOD_CYCLES = 1000,
  parameter int unsigned MAX_MISSES    = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_TASKS-1:0]              task_alive,
  input  logic                              clear_fault,
  output logic                              generate_bit,
  output logic                              fault,
  output logic [NUM_TASKS-1:0]              missed_mask,
  output logic [$clog2(MAX_MISSES+1)-1:0]   miss_count
);

  localparam int unsigned WIN_W  = $clog2(PERIOD_CYCLES);
  localparam int unsigned MISS_W = $clog2(MAX_MISSES+1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(PERIOD_CYCLES-1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [NUM_TASKS-1:0]   seen_q, seen_d;
  logic                   generate_bit_q, generate_bit_d;
  logic                   fault_q, fault_d;
  logic [NUM_TASKS-1:0]   missed_mask_q, missed_mask_d;
  logic [MISS_W-1:0]      miss_count_q, miss_count_d;

  logic [NUM_TASKS-1:0]   seen_f;
  logic [MISS_W-1:0]      miss_inc;

  always_comb begin
    state_d        = state_q;
    win_cnt_d      = win_cnt_q;
    seen_d         = seen_q;
    generate_bit_d = 1'b0;
    fault_d        = fault_q;
    missed_mask_d  = missed_mask_q;
    miss_count_d   = miss_count_q;
    // A check-in on the closing cycle still counts for the window being closed.
    seen_f         = seen_q | task_alive;
    miss_inc       = miss_count_q + MISS_W'(1);

    unique case (state_q)
      S_IDLE: begin
        win_cnt_d = '0;
        seen_d    = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_d   = S_IDLE;
          win_cnt_d = '0;
          seen_d    = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          win_cnt_d     = '0;
          seen_d        = '0;
          missed_mask_d = ~seen_f;
          if (&seen_f) begin
            generate_bit_d = 1'b1;
            miss_count_d   = '0;
          end else begin
            miss_count_d = miss_inc;
            if (miss_inc == MISS_MAX) begin
              state_d = S_FAULT;
              fault_d = 1'b1;
            end
          end
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          seen_d    = seen_f;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
        if (clear_fault) begin
          state_d       = S_IDLE;
          fault_d       = 1'b0;
          miss_count_d  = '0;
          missed_mask_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      win_cnt_q      <= '0;
      seen_q         <= '0;
      generate_bit_q <= 1'b0;
      fault_q        <= 1'b0;
      missed_mask_q  <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      win_cnt_q      <= win_cnt_d;
      seen_q         <= seen_d;
      generate_bit_q <= generate_bit_d;
      fault_q        <= fault_d;
      missed_mask_q  <= missed_mask_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign generate_bit = generate_bit_q;
  assign fault        = fault_q;
  assign missed_mask  = missed_mask_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_doc_safety_heartbeat_sched.sv
// Directed bench for doc_safety_heartbeat_sched with NUM_TASKS=4, PERIOD_CYCLES=8, MAX_MISSES=3.
module tb_doc_safety_heartbeat_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] task_alive;
  logic       clear_fault;
  logic       generate_bit;
  logic       fault;
  logic [3:0] missed_mask;
  logic [1:0] miss_count;

  int checks = 0;
  int errors = 0;

  doc_safety_heartbeat_sched #(
    .NUM_TASKS    (4),
    .PERIOD_CYCLES(8),
    .MAX_MISSES   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .task_alive  (task_alive),
    .clear_fault (clear_fault),
    .generate_bit(generate_bit),
    .fault       (fault),
    .missed_mask (missed_mask),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full window starting at win_cnt==0; m_early is driven at win_cnt==2,
  // m_late at win_cnt==late_at. Checks no pulse mid-window and the closing outputs.
  task automatic window(input string name, input logic [3:0] m_early, input logic [3:0] m_late,
                        input int late_at, input logic exp_gen, input logic [3:0] exp_mask,
                        input logic [1:0] exp_miss, input logic exp_fault);
    for (int c = 0; c < 8; c++) begin
      task_alive = 4'b0000;
      if (c == 2) task_alive = task_alive | m_early;
      if (c == late_at) task_alive = task_alive | m_late;
      step();
      if (c < 7) begin
        checks++;
        if (generate_bit !== 1'b0) begin
          errors++;
          $display("FAIL %s mid-window gen c=%0d: got %b want 0", name, c, generate_bit);
        end
      end
    end
    task_alive = 4'b0000;
    checks++;
    if (generate_bit !== exp_gen) begin
      errors++;
      $display("FAIL %s gen: got %b want %b", name, generate_bit, exp_gen);
    end
    checks++;
    if (missed_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s missed_mask: got %b want %b", name, missed_mask, exp_mask);
    end
    checks++;
    if (miss_count !== exp_miss) begin
      errors++;
      $display("FAIL %s miss_count: got %0d want %0d", name, miss_count, exp_miss);
    end
    checks++;
    if (fault !== exp_fault) begin
      errors++;
      $display("FAIL %s fault: got %b want %b", name, fault, exp_fault);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; task_alive = 4'b1111; clear_fault = 1'b0;
    step(); step();
    checks++;
    if ({generate_bit, fault, missed_mask, miss_count} !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: got gen=%b fault=%b mask=%b miss=%0d want all 0",
               generate_bit, fault, missed_mask, miss_count);
    end
    reset = 1'b0; enable = 1'b0; task_alive = 4'b0000;
    step(); step();
    checks++;
    if ({generate_bit, fault, missed_mask, miss_count} !== 8'h00) begin
      errors++;
      $display("FAIL idle outputs: got gen=%b fault=%b mask=%b miss=%0d want all 0",
               generate_bit, fault, missed_mask, miss_count);
    end
  endtask

  task automatic test_normal();
    enable = 1'b1;
    step();
    for (int w = 0; w < 3; w++)
      window("normal", 4'b1111, 4'b0000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_single_miss();
    window("task2_silent", 4'b1011, 4'b0000, 0, 1'b0, 4'b0100, 2'd1, 1'b0);
    window("task2_recover", 4'b1111, 4'b0000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_boundary();
    window("late_last_cycle", 4'b0111, 4'b1000, 7, 1'b1, 4'b0000, 2'd0, 1'b0);
    window("before_cnt0", 4'b0111, 4'b0000, 0, 1'b0, 4'b1000, 2'd1, 1'b0);
    window("at_cnt0", 4'b0111, 4'b1000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_fault();
    window("fault_miss1", 4'b1110, 4'b0000, 0, 1'b0, 4'b0001, 2'd1, 1'b0);
    window("fault_miss2", 4'b1110, 4'b0000, 0, 1'b0, 4'b0001, 2'd2, 1'b0);
    window("fault_miss3", 4'b1110, 4'b0000, 0, 1'b0, 4'b0001, 2'd3, 1'b1);
    window("fault_sticky", 4'b1111, 4'b0000, 0, 1'b0, 4'b0001, 2'd3, 1'b1);
  endtask

  task automatic test_clear_fault();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    checks++;
    if ({generate_bit, fault, missed_mask, miss_count} !== 8'h00) begin
      errors++;
      $display("FAIL clear_fault outputs: got gen=%b fault=%b mask=%b miss=%0d want all 0",
               generate_bit, fault, missed_mask, miss_count);
    end
    step();
    window("after_clear", 4'b1111, 4'b0000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_enable_drop();
    window("pre_drop_fail", 4'b0000, 4'b0000, 0, 1'b0, 4'b1111, 2'd1, 1'b0);
    task_alive = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    enable = 1'b0;
    task_alive = 4'b0000;
    for (int c = 0; c < 9; c++) begin
      step();
      checks++;
      if (generate_bit !== 1'b0 || missed_mask !== 4'b1111 || miss_count !== 2'd1) begin
        errors++;
        $display("FAIL enable_drop held c=%0d: got gen=%b mask=%b miss=%0d want gen=0 mask=1111 miss=1",
                 c, generate_bit, missed_mask, miss_count);
      end
    end
    enable = 1'b1;
    step();
    window("after_reenable", 4'b1111, 4'b0000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_reset_on_pulse();
    window("pre_reset_fail", 4'b1101, 4'b0000, 0, 1'b0, 4'b0010, 2'd1, 1'b0);
    window("pre_reset_pulse", 4'b1111, 4'b0000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({generate_bit, fault, missed_mask, miss_count} !== 8'h00) begin
      errors++;
      $display("FAIL reset_on_pulse outputs: got gen=%b fault=%b mask=%b miss=%0d want all 0",
               generate_bit, fault, missed_mask, miss_count);
    end
    step();
    window("post_reset_window", 4'b1111, 4'b0000, 0, 1'b1, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_clear_outside_fault();
    window("cof_fail", 4'b0011, 4'b0000, 0, 1'b0, 4'b1100, 2'd1, 1'b0);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    checks++;
    if (missed_mask !== 4'b1100 || miss_count !== 2'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL clear_outside_fault: got mask=%b miss=%0d fault=%b want mask=1100 miss=1 fault=0",
               missed_mask, miss_count, fault);
    end
    for (int c = 1; c < 8; c++) step();
    checks++;
    if (miss_count !== 2'd2) begin
      errors++;
      $display("FAIL clear_outside_fault count: got %0d want 2", miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_single_miss();
    test_boundary();
    test_fault();
    test_clear_fault();
    test_enable_drop();
    test_reset_on_pulse();
    test_clear_outside_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
